// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM burst reader: controller states,
// output FIFO geometry and an address-width helper.
package ram_reader_pkg;

    // Controller states: waiting, issuing reads, emptying the FIFO.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // The output FIFO holds two bytes. Two entries are enough to cover the
    // one-cycle RAM latency and still stream one byte per clock.
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    // Address width for a byte RAM of kb KiB.
    function automatic int addr_width(input int kb);
        return $clog2(kb * 1024);
    endfunction

endpackage

// File: rtl/ram_reader_if.sv
// RAM port and byte-stream port of the reader, bundled together.
// The master side is the reader; the slave side is the RAM plus the consumer.
interface ram_reader_if #(
    parameter int AW = 14
);
    // RAM side
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_q;

    // Stream side
    logic [7:0]    q_data;
    logic          q_valid;
    logic          q_ready;

    modport master (
        output ram_ce,
        output ram_we,
        output ram_a,
        input  ram_q,
        output q_data,
        output q_valid,
        input  q_ready
    );

    modport slave (
        input  ram_ce,
        input  ram_we,
        input  ram_a,
        output ram_q,
        input  q_data,
        input  q_valid,
        output q_ready
    );

endinterface

// File: rtl/ram_reader_fifo.sv
// Two-entry byte FIFO between the RAM read port and the output stream.
// The head entry drives the stream directly, so it stays put until popped.
module ram_reader_fifo
    import ram_reader_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       wdata,
    input  logic             pop,
    output logic [7:0]       head,
    output logic [LVL_W-1:0] level
);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    // The controller never overfills or over-drains; the guards keep the
    // pointers coherent even if it did.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; everything clears on reset so no
    // stale byte can surface after a burst is abandoned.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/ram_reader.sv
// Burst reader: on start, reads count bytes from a byte-wide synchronous RAM
// beginning at base (address wraps at the top of the RAM) and streams them
// out over a valid/ready port. Reads are throttled so that bytes held in the
// FIFO plus the read in flight never exceed the FIFO depth.
module ram_reader
    import ram_reader_pkg::*;
#(
    parameter  int KB = 16,
    localparam int AW = addr_width(KB)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [15:0]   count,
    output logic          busy,
    output logic          done,
    ram_reader_if.master  bus
);

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    addr;
    logic [15:0]      remaining;
    logic             inflight;
    logic             done_q;
    logic             done_nx;
    logic             ce;
    logic             xfer;
    logic             q_valid;
    logic [7:0]       head;
    logic [LVL_W-1:0] level;
    logic [LVL_W:0]   pending;
    logic             last_xfer;

    // Output byte stream comes straight from the FIFO head.
    assign q_valid = (level != '0);
    assign xfer    = q_valid && bus.q_ready;

    // Bytes that will still be owed after this edge: held + in flight, less
    // the one leaving now. A new read is only allowed if it fits.
    assign pending = (LVL_W + 1)'(level) + (LVL_W + 1)'(inflight)
                   - (LVL_W + 1)'(xfer);

    // The final byte leaves when nothing else is queued behind it.
    assign last_xfer = xfer && (level == LVL_W'(1)) && !inflight;

    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign bus.ram_ce  = ce;
    assign bus.ram_we  = 1'b1;
    assign bus.ram_a   = addr;
    assign bus.q_data  = head;
    assign bus.q_valid = q_valid;

    ram_reader_fifo u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (inflight),
        .wdata (bus.ram_q),
        .pop   (xfer),
        .head  (head),
        .level (level)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, read issue and done request.
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        ce       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != 16'd0) begin
                        state_nx = READ;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            READ: begin
                if ((remaining != 16'd0) && (pending < (LVL_W + 1)'(FIFO_DEPTH))) begin
                    ce = 1'b1;
                    if (remaining == 16'd1) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Address counter, remaining-read counter, in-flight flag and done pulse.
    // start is only honoured while idle, so a busy burst cannot be disturbed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= done_nx;
            inflight <= ce;
            if ((state == IDLE) && start) begin
                addr      <= base;
                remaining <= count;
            end else if (ce) begin
                addr      <= addr + AW'(1);
                remaining <= remaining - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: a behavioural RAM, a valid/ready consumer and a
// transaction-level reference model (bytes issued / delivered, availability
// times and expected data) checked every cycle.
module tb_ram_reader;

    localparam int KB     = 16;
    localparam int AW     = 14;
    localparam int RAM_SZ = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base  = '0;
    logic [15:0]   count = '0;
    logic          busy;
    logic          done;

    ram_reader_if #(.AW(AW)) bus ();

    ram_reader #(.KB(KB)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .base  (base),
        .count (count),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] ram_mem [RAM_SZ];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Synchronous byte RAM: data appears after the edge that samples ce=1.
    always @(posedge clock) begin
        if (bus.ram_ce) bus.ram_q <= ram_mem[bus.ram_a];
    end

    // Consumer: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    int ready_mode = 0;
    int phase      = 0;
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       bus.q_ready = 1'b1;
            1:       bus.q_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
            default: bus.q_ready = 1'($urandom_range(0, 1));
        endcase
        phase = phase + 1;
    end

    // Reference model state.
    bit            active    = 0;
    bit            done_pend = 0;
    int            cur_count = 0;
    logic [AW-1:0] cur_base  = '0;
    int            issued    = 0;
    int            delivered = 0;
    int            cyc       = 0;
    int            start_cyc = 0;
    int            first_lat = -1;
    int            last_xcyc = 0;
    int            max_gap   = 0;
    int            ce_total  = 0;
    int            done_total = 0;
    int            avail_q[$];

    // Per-cycle monitor, sampling on the falling edge.
    always @(negedge clock) begin
        cyc++;
        check_val("ram_we", 32'(bus.ram_we), 32'd1);
        if (bus.ram_ce) ce_total++;
        if (done) done_total++;
        if (!reset) begin
            check_val("rst_busy",    32'(busy),        32'd0);
            check_val("rst_done",    32'(done),        32'd0);
            check_val("rst_ce",      32'(bus.ram_ce),  32'd0);
            check_val("rst_ram_a",   32'(bus.ram_a),   32'd0);
            check_val("rst_q_valid", 32'(bus.q_valid), 32'd0);
            check_val("rst_q_data",  32'(bus.q_data),  32'd0);
            active    = 0;
            done_pend = 0;
            issued    = 0;
            delivered = 0;
            avail_q.delete();
        end else begin
            bit            ce_exp;
            bit            qv_exp;
            bit            xfer;
            bit            accept;
            int            outstanding;
            logic [AW-1:0] a_exp;
            logic [AW-1:0] d_addr;
            outstanding = issued - delivered;
            qv_exp = active && (avail_q.size() > 0) && (avail_q[0] <= cyc);
            xfer   = qv_exp && bus.q_ready;
            ce_exp = active && (issued < cur_count) && ((outstanding - int'(xfer)) < 2);
            check_val("busy",    32'(busy),        32'(active));
            check_val("done",    32'(done),        32'(done_pend));
            check_val("ram_ce",  32'(bus.ram_ce),  32'(ce_exp));
            check_val("q_valid", 32'(bus.q_valid), 32'(qv_exp));
            if (ce_exp) begin
                a_exp = cur_base + AW'(issued);
                check_val("ram_a", 32'(bus.ram_a), 32'(a_exp));
            end
            if (qv_exp) begin
                d_addr = cur_base + AW'(delivered);
                check_val("q_data", 32'(bus.q_data), 32'(ram_mem[d_addr]));
            end
            accept    = !active && start;
            done_pend = 0;
            if (ce_exp) begin
                avail_q.push_back(cyc + 2);
                issued++;
            end
            if (xfer) begin
                void'(avail_q.pop_front());
                if (first_lat < 0) first_lat = cyc - start_cyc;
                else if ((cyc - last_xcyc) > max_gap) max_gap = cyc - last_xcyc;
                last_xcyc = cyc;
                delivered++;
                if (delivered == cur_count) begin
                    active    = 0;
                    done_pend = 1;
                end
            end
            if (accept) begin
                cur_base  = base;
                cur_count = int'(count);
                issued    = 0;
                delivered = 0;
                start_cyc = cyc;
                first_lat = -1;
                max_gap   = 0;
                if (count == 16'd0) done_pend = 1;
                else active = 1;
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input int c);
        @(posedge clock); #1;
        start = 1'b1;
        base  = b;
        count = 16'(c);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((active || done_pend) && (n < limit)) begin
            @(negedge clock); #1;
            n++;
        end
        check_val("idle_in_time", 32'(n < limit), 32'd1);
    endtask

    task automatic run_burst(input string tag, input logic [AW-1:0] b, input int c);
        int d0;
        d0 = done_total;
        do_start(b, c);
        wait_idle(2000);
        repeat (2) @(posedge clock);
        #1;
        check_val({tag, "_bytes"}, 32'(delivered), 32'(c));
        check_val({tag, "_done"},  32'(done_total - d0), 32'd1);
    endtask

    initial begin
        int c0;
        int d0;
        int n;
        for (int i = 0; i < RAM_SZ; i++) ram_mem[i] = 8'(i);

        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);

        // Basic burst, consumer always ready.
        ready_mode = 0;
        run_burst("s1", 14'h0100, 4);
        check_val("s1_latency", 32'(first_lat), 32'd3);
        check_val("s1_gap",     32'(max_gap),   32'd1);

        // Address wrap at the top of the RAM.
        run_burst("s2", 14'h3FFE, 4);
        check_val("s2_gap", 32'(max_gap), 32'd1);

        // Back-pressure with the 1,0,0,1 ready pattern.
        ready_mode = 1;
        run_burst("s3", 14'h0A55, 8);

        // Zero-length burst.
        ready_mode = 0;
        c0 = ce_total;
        run_burst("s4", 14'h0200, 0);
        check_val("s4_no_ce", 32'(ce_total - c0), 32'd0);

        // Start while busy is ignored; reset after two of six bytes.
        d0 = done_total;
        do_start(14'h0200, 6);
        do_start(14'h1234, 5);
        n = 0;
        while ((delivered < 2) && (n < 100)) begin
            @(negedge clock); #1;
            n++;
        end
        check_val("s5_two_bytes_in_time", 32'(n < 100), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check_val("s5_no_done", 32'(done_total - d0), 32'd0);
        run_burst("s5_after", 14'h0300, 5);

        // Randomized bursts under random consumer behaviour.
        for (int k = 0; k < 12; k++) begin
            ready_mode = int'($urandom_range(0, 2));
            run_burst("rnd", AW'($urandom), int'($urandom_range(0, 20)));
            repeat (int'($urandom_range(0, 3))) @(posedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
